// File: rtl/fetch_queue_pkg.sv
// Shared parameters and helpers for the IF->ID fetch queue.
// Defaults match the pipeline bus width and queue depth used by mycpu.
package fetch_queue_pkg;

  localparam int FQ_BUS_WD = 69;
  localparam int FQ_DEPTH  = 4;

  typedef enum logic [1:0] {
    FQ_OP_NONE = 2'b00,
    FQ_OP_POP  = 2'b01,
    FQ_OP_PUSH = 2'b10,
    FQ_OP_BOTH = 2'b11
  } fq_op_e;

  function automatic int fq_ptr_wd(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_queue_regfile.sv
// DEPTH x BUS_WD storage: one synchronous write port, one asynchronous read port.
// Data is never reset; validity is tracked by the queue controller.
module fetch_queue_regfile #(
  parameter int BUS_WD = 69,
  parameter int DEPTH  = 4,
  parameter int PTR_WD = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_WD-1:0] i_waddr,
  input  logic [BUS_WD-1:0] i_wdat,
  input  logic [PTR_WD-1:0] i_raddr,
  output logic [BUS_WD-1:0] o_rdat
);

  logic [BUS_WD-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order decoupling FIFO between if_stage and id_stage; push visible at head next cycle.
// Allowin depends only on registered occupancy, so a full queue refuses input even while popping.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int BUS_WD = FQ_BUS_WD,
  parameter int DEPTH  = FQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fs_to_fq_valid,
  input  logic [BUS_WD-1:0]           fs_to_fq_bus,
  output logic                        fq_allowin,
  output logic                        fq_to_ds_valid,
  output logic [BUS_WD-1:0]           fq_to_ds_bus,
  input  logic                        ds_allowin,
  input  logic                        flush,
  output logic [$clog2(DEPTH):0]      fq_count
);

  localparam int PTR_WD = fq_ptr_wd(DEPTH);
  localparam int CNT_WD = PTR_WD + 1;

  logic [PTR_WD-1:0] r_wr_ptr;
  logic [PTR_WD-1:0] r_rd_ptr;
  logic [CNT_WD-1:0] r_count;
  logic              w_push;
  logic              w_pop;
  fq_op_e            w_op;

  assign fq_allowin     = (r_count != CNT_WD'(DEPTH));
  assign fq_to_ds_valid = (r_count != '0);
  assign fq_count       = r_count;

  // Flush kills both sides of the handshake so no wrong-path bundle is retained.
  assign w_push = fs_to_fq_valid && fq_allowin && !flush;
  assign w_pop  = fq_to_ds_valid && ds_allowin && !flush;

  always_comb begin
    w_op = FQ_OP_NONE;
    case ({w_push, w_pop})
      2'b10:   w_op = FQ_OP_PUSH;
      2'b01:   w_op = FQ_OP_POP;
      2'b11:   w_op = FQ_OP_BOTH;
      default: w_op = FQ_OP_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (w_op)
        FQ_OP_PUSH: begin
          r_wr_ptr <= r_wr_ptr + PTR_WD'(1);
          r_count  <= r_count + CNT_WD'(1);
        end
        FQ_OP_POP: begin
          r_rd_ptr <= r_rd_ptr + PTR_WD'(1);
          r_count  <= r_count - CNT_WD'(1);
        end
        FQ_OP_BOTH: begin
          r_wr_ptr <= r_wr_ptr + PTR_WD'(1);
          r_rd_ptr <= r_rd_ptr + PTR_WD'(1);
        end
        default: ;
      endcase
    end
  end

  fetch_queue_regfile #(
    .BUS_WD (BUS_WD),
    .DEPTH  (DEPTH),
    .PTR_WD (PTR_WD)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_push && !reset),
    .i_waddr (r_wr_ptr),
    .i_wdat  (fs_to_fq_bus),
    .i_raddr (r_rd_ptr),
    .o_rdat  (fq_to_ds_bus)
  );

endmodule
